// File: rtl/com_ctrl.sv
// sys_clk-side protocol controller: accepts fs_read packets, decodes the command, replies via fs_send.
// fd_read follows fs_read by 1 cycle; fs_send rises 2 cycles after fd_read falls; an unanswered send aborts after TIMEOUT_CYC cycles.
module com_ctrl #(
    parameter int          TIMEOUT_CYC = 4096,
    parameter logic [11:0] MAX_DLEN    = 12'd2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs_read,
    input  logic [3:0]  read_btype,
    input  logic [31:0] cache_cmd,
    output logic        fd_read,
    output logic        fs_send,
    output logic [3:0]  send_btype,
    output logic [11:0] send_dlen,
    output logic [11:0] ram_addr_init,
    input  logic        fd_send,
    output logic [31:0] cfg_reg,
    output logic        cfg_vld,
    output logic        busy,
    output logic [7:0]  err_cnt
);
    typedef enum logic [2:0] {IDLE, ACK_RX, DECODE, SEND, RELEASE} state_t;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t      state, next_state;
    logic [TW-1:0] tcnt;
    logic [3:0]  rx_btype;
    logic [31:0] rx_cmd;
    logic [11:0] req_addr, req_dlen;
    logic        req_bad, tmo, err_inc;

    assign req_addr = rx_cmd[11:0];
    assign req_dlen = rx_cmd[23:12];
    assign req_bad  = (req_dlen == 12'd0) || (req_dlen > MAX_DLEN);
    assign tmo      = (tcnt == TW'(TIMEOUT_CYC - 1));

    assign fd_read = (state == ACK_RX);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        err_inc    = 1'b0;
        case (state)
            IDLE:    if (fs_read) next_state = ACK_RX;
            ACK_RX:  if (!fs_read) next_state = DECODE;
            DECODE: begin
                case (rx_btype)
                    4'h1, 4'h3: next_state = SEND;
                    4'h2: begin
                        next_state = SEND;
                        err_inc    = req_bad;
                    end
                    default: begin
                        next_state = IDLE;
                        err_inc    = 1'b1;
                    end
                endcase
            end
            // fd_send is only honoured once our own request is visible
            SEND: begin
                if (fs_send && fd_send) next_state = RELEASE;
                else if (tmo) begin
                    next_state = IDLE;
                    err_inc    = 1'b1;
                end
            end
            RELEASE: begin
                if (!fd_send) next_state = IDLE;
                else if (tmo) begin
                    next_state = IDLE;
                    err_inc    = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fs_send       <= 1'b0;
            send_btype    <= 4'h0;
            send_dlen     <= 12'd0;
            ram_addr_init <= 12'd0;
            cfg_reg       <= 32'd0;
            cfg_vld       <= 1'b0;
            err_cnt       <= 8'd0;
            tcnt          <= '0;
            rx_btype      <= 4'h0;
            rx_cmd        <= 32'd0;
        end else begin
            cfg_vld <= 1'b0;
            // registered one cycle after SEND entry; drops on the edge that leaves SEND
            fs_send <= (state == SEND) && (next_state == SEND);

            if ((next_state != state) && ((next_state == SEND) || (next_state == RELEASE)))
                tcnt <= '0;
            else if ((state == SEND) || (state == RELEASE))
                tcnt <= tcnt + 1'b1;

            if ((state == IDLE) && fs_read) begin
                rx_btype <= read_btype;
                rx_cmd   <= cache_cmd;
            end

            if (state == DECODE) begin
                case (rx_btype)
                    4'h1: begin
                        cfg_reg       <= rx_cmd;
                        cfg_vld       <= 1'b1;
                        send_btype    <= 4'h8;
                        send_dlen     <= 12'd0;
                        ram_addr_init <= 12'd0;
                    end
                    4'h2: begin
                        send_btype    <= req_bad ? 4'hF : 4'h9;
                        send_dlen     <= req_bad ? 12'd0 : req_dlen;
                        ram_addr_init <= req_bad ? 12'd0 : req_addr;
                    end
                    4'h3: begin
                        send_btype    <= 4'hA;
                        send_dlen     <= 12'd0;
                        ram_addr_init <= {4'h0, err_cnt};
                    end
                    default: ;
                endcase
            end

            if (err_inc && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_com_ctrl.sv
// Directed bench for com_ctrl with a reply scoreboard filled when each packet is offered.
module tb_com_ctrl;
    localparam int TO = 4096;

    logic        clk = 1'b0;
    logic        rst, fs_read, fd_send;
    logic [3:0]  read_btype;
    logic [31:0] cache_cmd;
    logic        fd_read, fs_send, cfg_vld, busy;
    logic [3:0]  send_btype;
    logic [11:0] send_dlen, ram_addr_init;
    logic [31:0] cfg_reg;
    logic [7:0]  err_cnt;

    com_ctrl #(.TIMEOUT_CYC(TO), .MAX_DLEN(12'd2048)) dut (
        .clk(clk), .rst(rst), .fs_read(fs_read), .read_btype(read_btype),
        .cache_cmd(cache_cmd), .fd_read(fd_read), .fs_send(fs_send),
        .send_btype(send_btype), .send_dlen(send_dlen), .ram_addr_init(ram_addr_init),
        .fd_send(fd_send), .cfg_reg(cfg_reg), .cfg_vld(cfg_vld), .busy(busy),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        none;
        logic [3:0]  bt;
        logic [11:0] dlen;
        logic [11:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          model_err = 0;
    logic [31:0] model_cfg = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bump_err();
        if (model_err < 255) model_err++;
    endtask

    task automatic push_expect(input logic [3:0] bt, input logic [31:0] cmd);
        exp_t e;
        e = '0;
        case (bt)
            4'h1: begin
                e.bt = 4'h8;
                model_cfg = cmd;
            end
            4'h2: begin
                if (cmd[23:12] == 12'd0 || cmd[23:12] > 12'd2048) begin
                    e.bt = 4'hF;
                    bump_err();
                end else begin
                    e.bt   = 4'h9;
                    e.dlen = cmd[23:12];
                    e.addr = cmd[11:0];
                end
            end
            4'h3: begin
                e.bt   = 4'hA;
                e.addr = {4'h0, 8'(model_err)};
            end
            default: begin
                e.none = 1'b1;
                bump_err();
            end
        endcase
        sb.push_back(e);
    endtask

    // called at a negedge with the DUT idle; returns at the negedge where the DUT sits in DECODE
    task automatic rx_pkt(input logic [3:0] bt, input logic [31:0] cmd);
        push_expect(bt, cmd);
        read_btype = bt;
        cache_cmd  = cmd;
        fs_read    = 1'b1;
        @(negedge clk);
        chk("fd_read_rise", 32'(fd_read), 32'd1);
        chk("busy_rx", 32'(busy), 32'd1);
        fs_read = 1'b0;
        @(negedge clk);
        chk("fd_read_fall", 32'(fd_read), 32'd0);
    endtask

    task automatic reply(input logic ack);
        exp_t e;
        logic [27:0] flds;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        @(negedge clk);
        chk("cfg_vld", 32'(cfg_vld), 32'(e.bt == 4'h8));
        chk("cfg_reg", cfg_reg, model_cfg);
        chk("fs_send_early", 32'(fs_send), 32'd0);
        if (e.none) begin
            chk("busy_noreply", 32'(busy), 32'd0);
            chk("err_noreply", 32'(err_cnt), 32'(model_err));
            return;
        end
        @(negedge clk);
        chk("fs_send_rise", 32'(fs_send), 32'd1);
        flds = {send_btype, send_dlen, ram_addr_init};
        chk("reply_fields", 32'(flds), 32'({e.bt, e.dlen, e.addr}));
        chk("cfg_vld_clear", 32'(cfg_vld), 32'd0);
        if (!ack) return;
        repeat (3) @(negedge clk);
        chk("fs_send_hold", 32'(fs_send), 32'd1);
        chk("fields_hold", 32'({send_btype, send_dlen, ram_addr_init}), 32'(flds));
        fd_send = 1'b1;
        @(negedge clk);
        chk("fs_send_fall", 32'(fs_send), 32'd0);
        chk("busy_release", 32'(busy), 32'd1);
        fd_send = 1'b0;
        @(negedge clk);
        chk("busy_done", 32'(busy), 32'd0);
        chk("fields_after", 32'({send_btype, send_dlen, ram_addr_init}), 32'(flds));
        chk("err_reply", 32'(err_cnt), 32'(model_err));
    endtask

    initial begin
        int n;
        rst = 1'b1; fs_read = 1'b0; fd_send = 1'b0;
        read_btype = 4'h0; cache_cmd = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_outs", 32'({fd_read, fs_send, busy, cfg_vld, send_btype, send_dlen}), 32'd0);
        chk("rst_cfg", cfg_reg, 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        rx_pkt(4'h1, 32'hDEADBEEF); reply(1'b1);
        rx_pkt(4'h2, {8'h00, 12'd512, 12'h100}); reply(1'b1);
        rx_pkt(4'h2, {8'h00, 12'd2048, 12'h7FF}); reply(1'b1);
        rx_pkt(4'h2, {8'h00, 12'd0, 12'h123}); reply(1'b1);
        rx_pkt(4'h2, {8'h00, 12'd2049, 12'h010}); reply(1'b1);
        chk("err_two_nak", 32'(err_cnt), 32'd2);
        rx_pkt(4'h3, 32'h0); reply(1'b1);
        rx_pkt(4'h7, 32'h0); reply(1'b1);

        // SEND lasts TIMEOUT_CYC cycles, the first of which precedes the registered fs_send
        rx_pkt(4'h1, 32'h12345678); reply(1'b0);
        n = 1;
        for (int k = 0; k < TO + 10 && fs_send; k++) begin
            @(negedge clk);
            if (fs_send) n++;
        end
        bump_err();
        chk("timeout_len", 32'(n), 32'(TO - 1));
        chk("timeout_busy", 32'(busy), 32'd0);
        chk("timeout_err", 32'(err_cnt), 32'(model_err));
        rx_pkt(4'h1, 32'hA5A5_0001); reply(1'b1);

        for (int i = 0; i < 300 && model_err < 255; i++) begin
            rx_pkt(4'h7, 32'(i)); reply(1'b1);
        end
        chk("err_sat", 32'(err_cnt), 32'hFF);
        rx_pkt(4'hC, 32'h0); reply(1'b1);
        chk("err_sat_hold", 32'(err_cnt), 32'hFF);
        rx_pkt(4'h3, 32'h0); reply(1'b1);

        rx_pkt(4'h1, 32'hCAFEF00D); reply(1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_fs_send", 32'(fs_send), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_cfg", cfg_reg, 32'd0);
        chk("rst_mid_err", 32'(err_cnt), 32'd0);
        chk("rst_mid_fields", 32'({send_btype, send_dlen, ram_addr_init}), 32'd0);
        rst = 1'b0;
        model_err = 0;
        model_cfg = 32'd0;
        @(negedge clk);
        rx_pkt(4'h3, 32'h0); reply(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
